// File: rtl/timer_pkg.sv
// ============================================================================
// timer_pkg : shared types and constants for the timer / capture blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

    localparam int PRESC_W       = 8;
    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } cap_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ============================================================================
// sync_edge_det : multi-flop synchronizer with rise/fall detection
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    input  logic track_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // While tracking, prev still follows s so re-enabling on a high input is edge-free.
    assign s_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = ~track_i &  s_o & ~prev_q;
    assign fall_o = ~track_i & ~s_o &  prev_q;

endmodule

`default_nettype wire

// File: rtl/timer_capture.sv
// ============================================================================
// timer_capture : input capture of period and high time in prescaled ticks
// Rev 1.0
// ============================================================================
`default_nettype none

module timer_capture
    import timer_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic [PRESC_W-1:0] prescaler_i,
    input  logic               cap_i,
    input  logic               clr_i,
    output logic [CNT_W-1:0]   period_o,
    output logic [CNT_W-1:0]   high_o,
    output logic               valid_o,
    output logic               overflow_o
);

    cap_state_e         state_q, state_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   hshadow_q, hshadow_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   high_q, high_d;
    logic               valid_q, valid_d;
    logic               overflow_q, overflow_d;

    logic               rise, fall, s_unused;
    logic               tick;
    logic [CNT_W-1:0]   cnt_inc;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (cap_i),
        .track_i (state_q == ST_IDLE),
        .s_o     (s_unused),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    assign tick    = (pcnt_q == prescaler_i);
    assign cnt_inc = cnt_q + CNT_W'(tick);

    always_comb begin
        state_d    = state_q;
        pcnt_d     = tick ? '0 : pcnt_q + PRESC_W'(1);
        cnt_d      = cnt_q;
        hshadow_d  = hshadow_q;
        period_d   = period_q;
        high_d     = high_q;
        // Clear first so a coincident set below wins.
        valid_d    = valid_q    & ~clr_i;
        overflow_d = overflow_q & ~clr_i;

        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    pcnt_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise) begin
                        cnt_d   = '0;
                        pcnt_d  = '0;
                        state_d = ST_HIGH;
                    end
                end
                ST_HIGH, ST_LOW: begin
                    if ((&cnt_q) && tick) begin
                        overflow_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_ARM;
                    end else if ((state_q == ST_HIGH) && fall) begin
                        hshadow_d = cnt_inc;
                        cnt_d     = cnt_inc;
                        state_d   = ST_LOW;
                    end else if ((state_q == ST_LOW) && rise) begin
                        period_d = cnt_inc;
                        high_d   = hshadow_q;
                        valid_d  = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_HIGH;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (state_q == ST_IDLE) begin
            pcnt_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            pcnt_q     <= '0;
            cnt_q      <= '0;
            hshadow_q  <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            cnt_q      <= cnt_d;
            hshadow_q  <= hshadow_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign period_o   = period_q;
    assign high_o     = high_q;
    assign valid_o    = valid_q;
    assign overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_capture.sv
// ============================================================================
// tb_timer_capture : directed and randomized checks of timer_capture
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_timer_capture;

    localparam int CNT_W = 4;
    localparam int SYNC  = 2;
    localparam int M_IDLE = 0, M_ARM = 1, M_HIGH = 2, M_LOW = 3;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             en_i = 1'b0;
    logic [7:0]       prescaler_i = 8'd0;
    logic             cap_i = 1'b0;
    logic             clr_i = 1'b0;
    logic [CNT_W-1:0] period_o, high_o;
    logic             valid_o, overflow_o;

    int total = 0;
    int bad   = 0;

    timer_capture #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .prescaler_i (prescaler_i),
        .cap_i       (cap_i),
        .clr_i       (clr_i),
        .period_o    (period_o),
        .high_o      (high_o),
        .valid_o     (valid_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ticks counted as plain integers since the last rise,
    // tick phase derived from cycles elapsed since the prescaler restart.
    int m_mode = M_IDLE;
    int m_n = 0, m_hs = 0, m_ph = 0, m_per = 0, m_hi = 0;
    bit m_val = 0, m_ovf = 0;
    bit hist [0:SYNC];

    always @(posedge clk_i) begin
        bit r, f, t;
        int ph_next;
        if (!rst_ni) begin
            m_mode = M_IDLE; m_n = 0; m_hs = 0; m_ph = 0;
            m_per = 0; m_hi = 0; m_val = 0; m_ovf = 0;
            for (int i = 0; i <= SYNC; i++) hist[i] = 1'b0;
        end else begin
            r = hist[SYNC-1] && !hist[SYNC] && (m_mode != M_IDLE);
            f = !hist[SYNC-1] && hist[SYNC] && (m_mode != M_IDLE);
            t = ((m_ph % (int'(prescaler_i) + 1)) == int'(prescaler_i));
            ph_next = (m_mode == M_IDLE) ? 0 : m_ph + 1;
            if (clr_i) begin
                m_val = 0;
                m_ovf = 0;
            end
            if (!en_i) begin
                m_mode = M_IDLE;
            end else if (m_mode == M_IDLE) begin
                m_mode = M_ARM;
            end else if (m_mode == M_ARM) begin
                if (r) begin
                    m_mode = M_HIGH; m_n = 0; ph_next = 0;
                end
            end else begin
                if (t && (m_n + 1 == (1 << CNT_W))) begin
                    m_ovf = 1; m_n = 0; m_mode = M_ARM;
                end else if (m_mode == M_HIGH && f) begin
                    m_n  = m_n + int'(t);
                    m_hs = m_n;
                    m_mode = M_LOW;
                end else if (m_mode == M_LOW && r) begin
                    m_per = m_n + int'(t);
                    m_hi  = m_hs;
                    m_val = 1;
                    m_n   = 0;
                    m_mode = M_HIGH;
                end else begin
                    m_n = m_n + int'(t);
                end
            end
            m_ph = ph_next;
            for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = cap_i;
        end
    end

    always @(posedge clk_i) begin
        #1;
        chk("model_period",   int'(period_o),   m_per);
        chk("model_high",     int'(high_o),     m_hi);
        chk("model_valid",    int'(valid_o),    int'(m_val));
        chk("model_overflow", int'(overflow_o), int'(m_ovf));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wave(input int per, input int hi, input int n);
        repeat (n) begin
            cap_i = 1'b1; cyc(hi);
            cap_i = 1'b0; cyc(per - hi);
        end
    endtask

    task automatic restart(input int presc);
        en_i = 1'b0; cyc(3);
        prescaler_i = 8'(presc);
        en_i = 1'b1; cyc(2);
    endtask

    initial begin
        cyc(3);
        chk("reset_period", int'(period_o), 0);
        chk("reset_high",   int'(high_o),   0);
        chk("reset_valid",  int'(valid_o),  0);
        chk("reset_ovf",    int'(overflow_o), 0);
        rst_ni = 1'b1; en_i = 1'b1; cyc(3);

        wave(10, 4, 3);
        chk("p0_period", int'(period_o), 10);
        chk("p0_high",   int'(high_o),   4);
        chk("p0_valid",  int'(valid_o),  1);

        restart(1);
        wave(20, 6, 3);
        chk("p1_period", int'(period_o), 10);
        chk("p1_high",   int'(high_o),   3);

        restart(3);
        wave(40, 10, 2);
        chk("p3_period", int'(period_o), 10);
        chk("p3_high",   int'(high_o),   2);

        restart(0);
        cap_i = 1'b1; cyc(40);
        cap_i = 1'b0; cyc(10);
        chk("sat_ovf",    int'(overflow_o), 1);
        chk("sat_valid",  int'(valid_o),    1);
        chk("sat_period", int'(period_o),   10);
        chk("sat_high",   int'(high_o),     2);
        wave(10, 4, 2);
        chk("post_sat_period", int'(period_o), 10);
        chk("post_sat_high",   int'(high_o),   4);

        clr_i = 1'b1; cyc(1); clr_i = 1'b0;
        chk("clr_valid", int'(valid_o),    0);
        chk("clr_ovf",   int'(overflow_o), 0);
        cap_i = 1'b1; cyc(2);
        clr_i = 1'b1; cyc(1); clr_i = 1'b0;
        chk("setwins_valid",  int'(valid_o),  1);
        chk("setwins_period", int'(period_o), 11);
        chk("setwins_high",   int'(high_o),   4);
        cyc(2);

        en_i = 1'b0; cyc(4);
        chk("dis_period", int'(period_o), 11);
        chk("dis_high",   int'(high_o),   4);
        chk("dis_valid",  int'(valid_o),  1);
        en_i = 1'b1; cyc(6);
        clr_i = 1'b1; cyc(1); clr_i = 1'b0;
        cap_i = 1'b0; cyc(5);
        cap_i = 1'b1; cyc(5);
        cap_i = 1'b0; cyc(5);
        chk("en_high_valid",  int'(valid_o),  0);
        chk("en_high_period", int'(period_o), 11);
        cap_i = 1'b1; cyc(3);
        chk("en_high_res_valid",  int'(valid_o),  1);
        chk("en_high_res_period", int'(period_o), 10);
        chk("en_high_res_high",   int'(high_o),   5);

        cyc(2); cap_i = 1'b0; cyc(4);
        rst_ni = 1'b0; #1;
        chk("async_rst_period", int'(period_o),   0);
        chk("async_rst_high",   int'(high_o),     0);
        chk("async_rst_valid",  int'(valid_o),    0);
        chk("async_rst_ovf",    int'(overflow_o), 0);
        cyc(2); rst_ni = 1'b1; cyc(2);
        wave(10, 4, 1);
        chk("rst_one_rise_valid", int'(valid_o), 0);
        wave(10, 4, 1);
        chk("rst_two_rise_valid",  int'(valid_o),  1);
        chk("rst_two_rise_period", int'(period_o), 10);
        chk("rst_two_rise_high",   int'(high_o),   4);

        repeat (400) begin
            int r, len;
            r = $urandom_range(0, 19);
            if (r == 0) restart($urandom_range(0, 2));
            else if (r == 1) begin en_i = 1'b0; cyc(1); en_i = 1'b1; end
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 9);
            cap_i = ~cap_i;
            clr_i = ($urandom_range(0, 9) == 0);
            cyc(1);
            clr_i = 1'b0;
            cyc(len - 1);
        end

        cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/timer_capture.md
Name: timer_capture

Overview:
Input-capture peripheral. It is the receive-side counterpart to the timer output block.
- Samples an external asynchronous pulse input.
- Measures the period (rising edge to rising edge) and the high time (rising edge to falling edge) in prescaled timer ticks.
- Presents the results to the MCU bus side with a sticky valid flag and a sticky overflow flag.
- Uses the same prescaler convention as the timer: divide by prescaler_i+1.

Parameters:
CNT_W, 16, width of the tick counter and of the captured results
SYNC_STAGES, 2, number of flops in the cap_i synchronizer (minimum 2)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  reset, asynchronous, active-low
en_i  input  1  capture enable; low forces IDLE
prescaler_i  input  8  tick = one clk_i every prescaler_i+1 cycles; 0 gives a tick every cycle
cap_i  input  1  external asynchronous signal to measure
clr_i  input  1  single-cycle pulse that clears valid_o and overflow_o
period_o  output  CNT_W  last complete period, in ticks
high_o  output  CNT_W  high time belonging to period_o, in ticks
valid_o  output  1  sticky; a new result is present
overflow_o  output  1  sticky; the counter saturated and the measurement was discarded

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, synchronizer flops 0.
- No derived clocks. All logic runs on clk_i; the prescaler produces a one-cycle tick enable.
- Synchronizer and edge detect:
  - cap_i passes through SYNC_STAGES flops, giving s.
  - prev holds s delayed by one cycle. rise = s & ~prev; fall = ~s & prev.
  - In IDLE, prev tracks s, so enabling while cap_i is high creates no spurious edge.
- Prescaler:
  - pcnt (8 bit). tick = (pcnt == prescaler_i).
  - On tick, pcnt <= 0; otherwise pcnt <= pcnt+1.
  - pcnt is forced to 0 in IDLE and on the arming rise.
  - A change of prescaler_i mid-measurement takes effect at the next compare. The result is then undefined but no lockup occurs: if pcnt > prescaler_i, pcnt wraps through 255.
- States:
  - IDLE: en_i=0. cnt <= 0. Outputs hold their values. Any state with en_i=0 goes to IDLE on the next cycle.
  - ARM: en_i=1, waiting for the first rise. On rise: cnt <= 0, pcnt <= 0, go to HIGH.
  - HIGH: on fall, hshadow <= cnt + tick, go to LOW.
  - LOW: on rise, period_o <= cnt + tick, high_o <= hshadow, valid_o <= 1, cnt <= 0, go to HIGH. pcnt is not reset, so measurement continues back-to-back.
- Counting in HIGH/LOW: on a tick with no edge, cnt <= cnt+1.
- Saturation:
  - If cnt is all ones and a tick occurs in HIGH or LOW: overflow_o <= 1, the measurement is discarded, cnt <= 0, go to ARM.
  - period_o, high_o and valid_o are untouched.
- Latency: cap_i rising at sampling edge k gives rise at edge k+SYNC_STAGES-1. period_o/valid_o update at edge k+SYNC_STAGES, i.e. 2 cycles at the default setting.
- Flag clearing:
  - clr_i clears valid_o and overflow_o.
  - If clr_i coincides with a new result, valid_o=1 (set wins). If clr_i coincides with saturation, overflow_o=1 (set wins).
- Unread result: a new result while valid_o=1 overwrites period_o/high_o. valid_o stays 1 and no extra flag is raised.
- Reset mid-measurement returns to reset values immediately (asynchronous).

Decomposition:
- Package timer_pkg holds:
  - state encoding enum (IDLE, ARM, HIGH, LOW);
  - PRESC_W = 8, shared with the timer block;
  - default CNT_W.
- One sub-module, sync_edge_det, parameterised by SYNC_STAGES:
  - inputs: async in, clear/track control;
  - outputs: s, rise, fall.

Test Plan:
- Period/high, default: prescaler_i=0; cap_i square wave, 10-cycle period, 4 high. After the second rise, expect period_o=10, high_o=4, valid_o=1. Results stay stable on subsequent periods.
- Prescaler: prescaler_i=1; period 20, high 6 (edges aligned to the first rise). Expect period_o=10, high_o=3. With prescaler_i=3 and period 40, expect period_o=10.
- Overflow, CNT_W=4: prescaler_i=0, cap_i held high for 40 cycles after a rise. Expect overflow_o=1, valid_o unchanged, state ARM. The next full 10-cycle period gives period_o=10.
- Flag priority: clr_i pulsed on the exact cycle a new result lands → valid_o stays 1. clr_i pulsed alone → valid_o=0 and overflow_o=0 the next cycle.
- Enable handling: en_i raised while cap_i=1 → no result until a full low-high-low-high sequence. Deasserting en_i mid-HIGH → state IDLE; period_o/high_o hold their last values.
- Reset: assert rst_ni low mid-LOW → all outputs 0 immediately. After release with en_i=1, the first valid result needs two rises.
